tl_mem_ctrl: RTL and testbench
==============================

TL_MEM_CTRL -- requirements
Module: tl_mem_ctrl

Interface
REQ-001 SHALL have parameters: ADDR_W, default 64, address width; DATA_W, default 64, beat width (fixed at 64); MEM_WORDS, default 1024, backing store depth in 64-bit words (power of 2); BASE_ADDR, default 0, byte address of word 0; LATENCY, default 2, cycles from accepting a request to its first response beat (1..15).
REQ-002 SHALL have one clock and an asynchronous active-high reset; all state SHALL be on the rising edge of clk_i.
REQ-003 SHALL have ports, one per line:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous active-high reset
- mem_a_opcode_i  in  3  0=PutFullData, 1=PutPartialData, 4=Get
- mem_a_param_i  in  3  ignored
- mem_a_size_i  in  3  log2 bytes
- mem_a_source_i  in  4  request tag
- mem_a_address_i  in  ADDR_W  byte address
- mem_a_mask_i  in  8  byte-lane write enables
- mem_a_data_i  in  DATA_W  write beat
- mem_a_valid_i  in  1  A beat valid
- mem_a_ready_o  out  1  A beat accepted
- mem_d_opcode_o  out  3  0=AccessAck, 1=AccessAckData
- mem_d_param_o  out  2  always 0
- mem_d_size_o  out  3  echoed request size
- mem_d_source_o  out  4  echoed request source
- mem_d_sink_o  out  2  always 0
- mem_d_denied_o  out  1  request refused
- mem_d_data_o  out  DATA_W  read beat
- mem_d_corrupt_o  out  1  equals denied on AccessAckData, else 0
- mem_d_valid_o  out  1  D beat valid
- mem_d_ready_i  in  1  D beat consumed

Function
REQ-004 SHALL handle one transaction at a time; FSM states IDLE, WBURST, WAIT, RDATA, WACK.
REQ-005 Beat count SHALL be 1 when size<=3, else 1<<(size-3) (size 6 = 8 beats, size 7 = 16 beats); beat counter 5 bits.
REQ-006 A request SHALL be denied when: opcode not in {0,1,4}; size==7; address not aligned to 2^size; or any addressed word outside [BASE_ADDR, BASE_ADDR+8*MEM_WORDS).
REQ-007 mem_a_ready_o SHALL be 1 only in IDLE and WBURST; a handshake is mem_a_valid_i & mem_a_ready_o.
REQ-008 IDLE: on handshake, latch opcode, size, source, word index, denied flag; Get -> WAIT; Put with beat count 1 -> WAIT; Put with more beats -> WBURST.
REQ-009 Each accepted Put beat SHALL write mem_a_data_i to word index+beat, byte lanes gated by mem_a_mask_i, in its handshake cycle; no write when denied; address/size/source of non-first beats ignored.
REQ-010 WBURST: after the last beat handshake -> WAIT.
REQ-011 WAIT: counter loaded with LATENCY-1 on entry, decremented per cycle; at zero -> RDATA (Get) or WACK (Put); a handshake at cycle T SHALL yield mem_d_valid_o at cycle T+LATENCY.
REQ-012 RDATA: mem_d_valid_o=1, opcode 1, data = word index+beat (0 when denied); beat advances on mem_d_valid_o & mem_d_ready_i; after last beat -> IDLE.
REQ-013 WACK: single AccessAck beat, data 0; on mem_d_ready_i -> IDLE.
REQ-014 D outputs SHALL remain stable while mem_d_valid_o=1 and mem_d_ready_i=0.
REQ-015 Read data SHALL reflect all writes committed before the read's handshake; backing store is never reset.
REQ-016 Denied Put bursts SHALL still consume all beats before the AccessAck.
REQ-017 Next request SHALL be acceptable in the cycle after the final D handshake (IDLE), not the same cycle.

Reset
REQ-018 rst_i asserted SHALL immediately force IDLE, mem_a_ready_o=0, mem_d_valid_o=0, all other D outputs 0, counters 0.
REQ-019 Reset mid-transaction SHALL abort it with no response; beats already written remain in memory.
REQ-020 mem_a_ready_o SHALL be 1 in the first cycle after rst_i deasserts.

Verification
REQ-021 PutFullData size 3 addr BASE_ADDR+0x40 data 0x1122334455667788 mask 0xFF, then Get size 3 same addr -> AccessAck at T+2, then AccessAckData data 0x1122334455667788, denied 0, source echoed.
REQ-022 PutPartialData mask 0x0F data 0xFFFFFFFFFFFFFFFF over word 0 -> subsequent Get returns 0x1122334455667788 pattern with low 4 bytes 0xFFFFFFFF, upper bytes unchanged.
REQ-023 8-beat PutFullData size 6 at 0x0 with data k, then Get size 6 with mem_d_ready_i toggled every other cycle -> 8 beats data 0..7 in order, outputs stable while stalled, single AccessAck for the Put.
REQ-024 Get size 3 at out-of-range address, and opcode 2 -> denied=1, corrupt=1 on the AccessAckData, data 0; memory unchanged.
REQ-025 Assert rst_i during beat 3 of an 8-beat Get -> mem_d_valid_o drops at once, mem_a_ready_o=1 the cycle after release, next Get completes normally.

Source files
------------

// File: rtl/tl_mem_ctrl.sv
// tl_mem_ctrl: single-outstanding TileLink-UL memory slave with fixed response latency
module tl_mem_ctrl #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64,
  parameter int MEM_WORDS = 1024,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter int LATENCY = 2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [2:0]        mem_a_opcode_i,
  input  logic [2:0]        mem_a_param_i,
  input  logic [2:0]        mem_a_size_i,
  input  logic [3:0]        mem_a_source_i,
  input  logic [ADDR_W-1:0] mem_a_address_i,
  input  logic [7:0]        mem_a_mask_i,
  input  logic [DATA_W-1:0] mem_a_data_i,
  input  logic              mem_a_valid_i,
  output logic              mem_a_ready_o,
  output logic [2:0]        mem_d_opcode_o,
  output logic [1:0]        mem_d_param_o,
  output logic [2:0]        mem_d_size_o,
  output logic [3:0]        mem_d_source_o,
  output logic [1:0]        mem_d_sink_o,
  output logic              mem_d_denied_o,
  output logic [DATA_W-1:0] mem_d_data_o,
  output logic              mem_d_corrupt_o,
  output logic              mem_d_valid_o,
  input  logic              mem_d_ready_i
);
  localparam int AW = $clog2(MEM_WORDS);
  typedef enum logic [2:0] {IDLE, WBURST, WAIT, RDATA, WACK} state_t;
  state_t state, state_n;
  logic put, den, hs, d_hs, last, a_put, a_den, wr_en, unused;
  logic [2:0] size;
  logic [3:0] source, cnt, cnt_n;
  logic [4:0] beat, beat_n, nbeats, a_beats;
  logic [AW-1:0] idx, wr_addr, rd_addr;
  logic [ADDR_W-1:0] off;
  logic [ADDR_W:0] end_word;
  logic [DATA_W-1:0] mem [MEM_WORDS];
  assign unused = ^mem_a_param_i;
  assign mem_a_ready_o = !rst_i && (state == IDLE || state == WBURST);
  assign hs = mem_a_valid_i & mem_a_ready_o;
  assign d_hs = mem_d_valid_o & mem_d_ready_i;
  assign last = beat == nbeats - 5'd1;
  assign a_put = mem_a_opcode_i == 3'd0 || mem_a_opcode_i == 3'd1;
  assign a_beats = mem_a_size_i <= 3'd3 ? 5'd1 : 5'd1 << (mem_a_size_i - 3'd3);
  assign off = mem_a_address_i - BASE_ADDR;
  assign end_word = {1'b0, off >> 3} + (ADDR_W+1)'(a_beats);
  // the whole burst must fit inside the window, not just its first word
  assign a_den = (!a_put && mem_a_opcode_i != 3'd4) || mem_a_size_i == 3'd7
    || |(mem_a_address_i & ((ADDR_W'(1) << mem_a_size_i) - ADDR_W'(1)))
    || mem_a_address_i < BASE_ADDR || end_word > (ADDR_W+1)'(MEM_WORDS);
  assign wr_en = hs && (state == IDLE ? a_put && !a_den : !den);
  assign wr_addr = state == IDLE ? off[AW+2:3] : idx + AW'(beat);
  assign rd_addr = idx + AW'(beat);
  assign mem_d_valid_o = state == RDATA || state == WACK;
  assign mem_d_opcode_o = {2'b0, state == RDATA};
  assign mem_d_param_o = '0;
  assign mem_d_sink_o = '0;
  assign mem_d_size_o = mem_d_valid_o ? size : '0;
  assign mem_d_source_o = mem_d_valid_o ? source : '0;
  assign mem_d_denied_o = mem_d_valid_o & den;
  assign mem_d_corrupt_o = state == RDATA && den;
  assign mem_d_data_o = (state == RDATA && !den) ? mem[rd_addr] : '0;
  always_comb begin
    state_n = state;
    beat_n = beat;
    cnt_n = cnt;
    case (state)
      IDLE: if (hs) begin
        cnt_n = 4'(LATENCY - 1);
        beat_n = (a_put && a_beats != 5'd1) ? 5'd1 : 5'd0;
        state_n = (a_put && a_beats != 5'd1) ? WBURST : LATENCY == 1 ? (a_put ? WACK : RDATA) : WAIT;
      end
      WBURST: if (hs) begin
        cnt_n = 4'(LATENCY - 1);
        beat_n = last ? 5'd0 : beat + 5'd1;
        state_n = !last ? WBURST : LATENCY == 1 ? WACK : WAIT;
      end
      WAIT: begin
        cnt_n = cnt <= 4'd1 ? 4'd0 : cnt - 4'd1;
        state_n = cnt > 4'd1 ? WAIT : put ? WACK : RDATA;
      end
      RDATA: if (d_hs) begin
        beat_n = last ? 5'd0 : beat + 5'd1;
        state_n = last ? IDLE : RDATA;
      end
      WACK: state_n = d_hs ? IDLE : WACK;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= IDLE;
      put <= 1'b0;
      den <= 1'b0;
      size <= '0;
      source <= '0;
      idx <= '0;
      nbeats <= '0;
      beat <= '0;
      cnt <= '0;
    end else begin
      state <= state_n;
      beat <= beat_n;
      cnt <= cnt_n;
      if (state == IDLE && hs) begin
        put <= a_put;
        den <= a_den;
        size <= mem_a_size_i;
        source <= mem_a_source_i;
        idx <= off[AW+2:3];
        nbeats <= a_beats;
      end
    end
  end
  // backing store is deliberately left out of reset
  always_ff @(posedge clk_i) begin
    if (wr_en)
      for (int i = 0; i < 8; i++)
        if (mem_a_mask_i[i]) mem[wr_addr][8*i +: 8] <= mem_a_data_i[8*i +: 8];
  end
endmodule

// File: tb/tb_tl_mem_ctrl.sv
// tb_tl_mem_ctrl: directed stimulus with a queue scoreboard checked by a D-channel monitor
module tb_tl_mem_ctrl;
  logic clk_i = 0, rst_i = 1;
  logic [2:0] mem_a_opcode_i = 0, mem_a_param_i = 0, mem_a_size_i = 0;
  logic [3:0] mem_a_source_i = 0;
  logic [63:0] mem_a_address_i = 0, mem_a_data_i = 0;
  logic [7:0] mem_a_mask_i = 0;
  logic mem_a_valid_i = 0, mem_a_ready_o;
  logic [2:0] mem_d_opcode_o, mem_d_size_o;
  logic [1:0] mem_d_param_o, mem_d_sink_o;
  logic [3:0] mem_d_source_o;
  logic mem_d_denied_o, mem_d_corrupt_o, mem_d_valid_o, mem_d_ready_i;
  logic [63:0] mem_d_data_o;

  tl_mem_ctrl dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .mem_a_opcode_i(mem_a_opcode_i), .mem_a_param_i(mem_a_param_i), .mem_a_size_i(mem_a_size_i),
    .mem_a_source_i(mem_a_source_i), .mem_a_address_i(mem_a_address_i), .mem_a_mask_i(mem_a_mask_i),
    .mem_a_data_i(mem_a_data_i), .mem_a_valid_i(mem_a_valid_i), .mem_a_ready_o(mem_a_ready_o),
    .mem_d_opcode_o(mem_d_opcode_o), .mem_d_param_o(mem_d_param_o), .mem_d_size_o(mem_d_size_o),
    .mem_d_source_o(mem_d_source_o), .mem_d_sink_o(mem_d_sink_o), .mem_d_denied_o(mem_d_denied_o),
    .mem_d_data_o(mem_d_data_o), .mem_d_corrupt_o(mem_d_corrupt_o), .mem_d_valid_o(mem_d_valid_o),
    .mem_d_ready_i(mem_d_ready_i)
  );

  always #5 clk_i = ~clk_i;
  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  typedef struct {
    logic [2:0] op;
    logic den;
    logic [2:0] size;
    logic [3:0] src;
    logic [63:0] data;
    int cyc;
  } exp_t;
  exp_t q[$];
  int n_pass = 0, n_chk = 0;
  logic stall = 0;

  task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  initial begin
    mem_d_ready_i = 1;
    forever begin
      @(posedge clk_i); #1;
      mem_d_ready_i = stall ? ~mem_d_ready_i : 1'b1;
    end
  end

  logic pv = 0, ph = 0, held = 0;
  logic [75:0] snap = 0;
  always @(negedge clk_i) begin
    exp_t e;
    logic [75:0] cur;
    cur = {mem_d_opcode_o, mem_d_denied_o, mem_d_corrupt_o, mem_d_size_o, mem_d_source_o, mem_d_data_o};
    if (mem_d_valid_o) begin
      if ((!pv || ph) && q.size() > 0 && q[0].cyc >= 0) chk("first_beat_cycle", 80'(cyc), 80'(q[0].cyc));
      if (held) chk("stall_hold", 80'(cur), 80'(snap));
      if (mem_d_ready_i) begin
        if (q.size() == 0) begin
          n_chk++;
          $display("FAIL unexpected_d: got %h expected no response", cur);
        end else begin
          e = q.pop_front();
          chk("d_beat", 80'(cur), 80'({e.op, e.den, e.den & (e.op == 3'd1), e.size, e.src, e.data}));
        end
      end
    end
    held = mem_d_valid_o & !mem_d_ready_i;
    snap = cur;
    pv = mem_d_valid_o;
    ph = mem_d_valid_o & mem_d_ready_i;
  end

  task automatic beat(input logic [2:0] op, input logic [2:0] size, input logic [3:0] src,
                      input logic [63:0] addr, input logic [7:0] mask, input logic [63:0] data, output int t);
    mem_a_opcode_i = op; mem_a_size_i = size; mem_a_source_i = src;
    mem_a_address_i = addr; mem_a_mask_i = mask; mem_a_data_i = data; mem_a_valid_i = 1;
    t = -1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk_i);
      if (mem_a_ready_o) begin t = cyc; break; end
    end
    if (t < 0) begin n_chk++; $display("FAIL a_ready_timeout: got 0 expected 1"); end
    @(posedge clk_i); #1;
    mem_a_valid_i = 0;
  endtask

  function automatic int nbeats(input logic [2:0] size);
    return size <= 3 ? 1 : 1 << (size - 3);
  endfunction

  task automatic put(input logic [2:0] op, input logic [2:0] size, input logic [3:0] src, input logic [63:0] addr,
                     input logic [7:0] mask, input logic [63:0] data, input bit inc, input bit den);
    int t;
    for (int k = 0; k < nbeats(size); k++) beat(op, size, src, addr, mask, data + (inc ? 64'(k) : 64'd0), t);
    q.push_back('{3'd0, den, size, src, 64'd0, t + 2});
  endtask

  task automatic get(input logic [2:0] op, input logic [2:0] size, input logic [3:0] src, input logic [63:0] addr,
                     input logic [63:0] data, input bit inc, input bit den);
    int t;
    beat(op, size, src, addr, 8'hFF, 64'hBAD0_BAD0_BAD0_BAD0, t);
    for (int k = 0; k < nbeats(size); k++)
      q.push_back('{3'd1, den, size, src, den ? 64'd0 : data + (inc ? 64'(k) : 64'd0), k == 0 ? t + 2 : -1});
  endtask

  task automatic drain();
    for (int i = 0; i < 300 && q.size() > 0; i++) @(negedge clk_i);
    if (q.size() > 0) begin
      n_chk++;
      $display("FAIL drain_timeout: got %0d pending expected 0", q.size());
      q.delete();
    end
    @(posedge clk_i); #1;
  endtask

  initial begin
    int t;
    repeat (3) @(negedge clk_i);
    chk("rst_a_ready", 80'(mem_a_ready_o), 0);
    chk("rst_d_valid", 80'(mem_d_valid_o), 0);
    chk("rst_d_outs", 80'({mem_d_opcode_o, mem_d_size_o, mem_d_source_o, mem_d_denied_o, mem_d_corrupt_o, mem_d_data_o}), 0);
    @(posedge clk_i); #1;
    rst_i = 0;
    @(negedge clk_i);
    chk("ready_after_rst", 80'(mem_a_ready_o), 1);
    @(posedge clk_i); #1;
    put(3'd0, 3'd3, 4'd3, 64'h40, 8'hFF, 64'h1122334455667788, 0, 0);
    get(3'd4, 3'd3, 4'd5, 64'h40, 64'h1122334455667788, 0, 0);
    put(3'd0, 3'd3, 4'd1, 64'h0, 8'hFF, 64'h1122334455667788, 0, 0);
    put(3'd1, 3'd3, 4'd2, 64'h0, 8'h0F, 64'hFFFFFFFFFFFFFFFF, 0, 0);
    get(3'd4, 3'd3, 4'd6, 64'h0, 64'h11223344FFFFFFFF, 0, 0);
    put(3'd0, 3'd6, 4'd4, 64'h0, 8'hFF, 64'd0, 1, 0);
    drain();
    stall = 1;
    get(3'd4, 3'd6, 4'd9, 64'h0, 64'd0, 1, 0);
    drain();
    stall = 0;
    get(3'd4, 3'd3, 4'd10, 64'h2000, 64'd0, 0, 1);
    get(3'd2, 3'd3, 4'd11, 64'h40, 64'd0, 0, 1);
    get(3'd4, 3'd3, 4'd12, 64'h44, 64'd0, 0, 1);
    put(3'd0, 3'd3, 4'd13, 64'h2000, 8'hFF, 64'hDEAD, 0, 1);
    put(3'd0, 3'd3, 4'd14, 64'h1FF8, 8'hFF, 64'hA5A5A5A5A5A5A5A5, 0, 0);
    put(3'd0, 3'd6, 4'd15, 64'h1FE0, 8'hFF, 64'hBEEF0000, 1, 1);
    get(3'd4, 3'd3, 4'd1, 64'h1FF8, 64'hA5A5A5A5A5A5A5A5, 0, 0);
    get(3'd4, 3'd3, 4'd2, 64'h40, 64'h1122334455667788, 0, 0);
    drain();
    beat(3'd4, 3'd6, 4'd7, 64'h0, 8'hFF, 64'd0, t);
    for (int k = 0; k < 3; k++) q.push_back('{3'd1, 1'b0, 3'd6, 4'd7, 64'(k), k == 0 ? t + 2 : -1});
    for (int i = 0; i < 50 && cyc != t + 5; i++) begin @(posedge clk_i); #1; end
    chk("pre_rst_beat3", 80'({mem_d_valid_o, mem_d_data_o}), 80'({1'b1, 64'd3}));
    chk("pre_rst_queue", 80'(q.size()), 0);
    rst_i = 1;
    #1;
    chk("rst_mid_d_valid", 80'(mem_d_valid_o), 0);
    chk("rst_mid_a_ready", 80'(mem_a_ready_o), 0);
    chk("rst_mid_d_outs", 80'({mem_d_opcode_o, mem_d_size_o, mem_d_source_o, mem_d_denied_o, mem_d_corrupt_o, mem_d_data_o}), 0);
    @(posedge clk_i); #1;
    rst_i = 0;
    @(negedge clk_i);
    chk("ready_after_mid_rst", 80'(mem_a_ready_o), 1);
    @(posedge clk_i); #1;
    get(3'd4, 3'd3, 4'd8, 64'h40, 64'h1122334455667788, 0, 0);
    get(3'd4, 3'd3, 4'd3, 64'h18, 64'd3, 0, 0);
    drain();
    repeat (5) @(negedge clk_i);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
